alu: RTL and testbench

// - 32-bit integer ALU for the Ewok RISC CPU datapath. The execute stage drives it.
// - Takes two operands and a 3-bit op code. Produces a registered result and a zero flag one clock later.
// - The zero flag feeds branch resolution in the CPU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_shifter.sv | 26 ++
 rtl/alu.sv | 69 ++++++
 tb/tb_alu.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, width and shifter mode encoding for the Ewok ALU
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter covering SLL, SRL and SRA
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_mode_e        mode,
    output logic [WIDTH-1:0]   y
);

    logic [WIDTH-1:0] sra;

    // Arithmetic shift kept in its own signed context so the sign fill survives
    assign sra = $unsigned($signed(a) >>> shamt);

    // Pick the shift flavour; logical right shift is the fallback
    always_comb begin
        y = (mode == SH_SLL) ? (a << shamt) :
            (mode == SH_SRA) ? sra :
                               (a >> shamt);
    end

endmodule

// File: rtl/alu.sv
// alu: 32-bit integer ALU with a single registered result and zero flag
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zeroFlag
);

    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;
    shift_mode_e      sh_mode;

    assign sh_mode = (op == ALU_SLL) ? SH_SLL :
                     (op == ALU_SRA) ? SH_SRA : SH_SRL;

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a     (a),
        .shamt (b[SHAMT_W-1:0]),
        .mode  (sh_mode),
        .y     (shift_y)
    );

    // Op mux producing the next result; every 3-bit code is a real operation
    always_comb begin
        result_d = '0;
        unique case (op)
            ALU_ADD: result_d = a + b;
            ALU_SUB: result_d = a - b;
            ALU_AND: result_d = a & b;
            ALU_OR:  result_d = a | b;
            ALU_XOR: result_d = a ^ b;
            default: result_d = shift_y;
        endcase
    end

    // Zero detect on the next result so the flag is registered alongside it
    always_comb begin
        zero_d = (result_d == '0);
    end

    // Output stage: reset clears the in-flight result and reports zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign zeroFlag = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed table-driven checks of the ALU plus reset sequences
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] result;
    logic        zeroFlag;

    int errors = 0;
    int checks = 0;

    vec_t vecs[18];

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .zeroFlag (zeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] exp_r, input logic exp_z);
        checks++;
        if (result !== exp_r || zeroFlag !== exp_z) begin
            errors++;
            $display("FAIL %s: result=%h zeroFlag=%b, expected result=%h zeroFlag=%b",
                     name, result, zeroFlag, exp_r, exp_z);
        end
    endtask

    initial begin
        vecs[0]  = '{ALU_ADD, 32'd5,          32'd10,         32'd15,         1'b0};
        vecs[1]  = '{ALU_SUB, 32'd10,         32'd5,          32'd5,          1'b0};
        vecs[2]  = '{ALU_SUB, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[3]  = '{ALU_ADD, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};
        vecs[4]  = '{ALU_AND, 32'd5,          32'd3,          32'd1,          1'b0};
        vecs[5]  = '{ALU_OR,  32'd5,          32'd3,          32'd7,          1'b0};
        vecs[6]  = '{ALU_XOR, 32'd5,          32'd3,          32'd6,          1'b0};
        vecs[7]  = '{ALU_XOR, 32'hA5A5A5A5,   32'hA5A5A5A5,   32'd0,          1'b1};
        vecs[8]  = '{ALU_SLL, 32'd5,          32'd2,          32'd20,         1'b0};
        vecs[9]  = '{ALU_SRL, 32'd4,          32'd2,          32'd1,          1'b0};
        vecs[10] = '{ALU_SRA, 32'h80000000,   32'd4,          32'hF8000000,   1'b0};
        vecs[11] = '{ALU_SRL, 32'h80000000,   32'd4,          32'h08000000,   1'b0};
        vecs[12] = '{ALU_SLL, 32'd1,          32'd33,         32'd2,          1'b0};
        vecs[13] = '{ALU_ADD, 32'd0,          32'd0,          32'd0,          1'b1};
        vecs[14] = '{ALU_SRA, 32'h7FFFFFF0,   32'd4,          32'h07FFFFFF,   1'b0};
        vecs[15] = '{ALU_SRA, 32'h80000001,   32'd32,         32'h80000001,   1'b0};
        vecs[16] = '{ALU_SRL, 32'h80000000,   32'd31,         32'd1,          1'b0};
        vecs[17] = '{ALU_SLL, 32'h00000003,   32'hFFFFFFFF,   32'h80000000,   1'b0};

        // Reset held with live inputs
        rst_n = 1'b0;
        a = 32'd5;
        b = 32'd10;
        op = ALU_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", 32'd0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", 32'd15, 1'b0);

        // Back-to-back vectors: each result must appear exactly one edge later
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            op = vecs[i].op;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vecs[i].res, vecs[i].z);
            @(negedge clk);
            if (i < 17)
                chk($sformatf("vec%0d_hold", i), vecs[i].res, vecs[i].z);
        end

        // Inputs changed mid-cycle must not reach the output before the edge
        a = 32'd7;
        b = 32'd8;
        op = ALU_ADD;
        #2;
        chk("no_early_update", vecs[17].res, vecs[17].z);
        @(posedge clk);
        #1;
        chk("add_7_8", 32'd15, 1'b0);

        // Asynchronous reset mid-stream clears outputs without an edge
        a = 32'd100;
        b = 32'd1;
        op = ALU_SUB;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("reset_discard", 32'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_sub", 32'd99, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
